// File: rtl/seq_restoring_divider.sv
// ============================================================================
// seq_restoring_divider : iterative unsigned restoring divider, one bit/clock
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   acc_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] q_next;
  logic             last;

  // acc < d always holds, so the shifted remainder fits WIDTH bits whenever
  // the trial subtraction goes negative and the restored value is kept.
  always_comb begin
    acc_sh   = {acc, q[WIDTH-1]};
    trial    = acc_sh - {1'b0, d};
    acc_next = trial[WIDTH] ? acc_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    q_next   = {q[WIDTH-2:0], ~trial[WIDTH]};
    last     = (count == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ready       <= 1'b1;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      acc         <= '0;
      q           <= '0;
      d           <= '0;
      count       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor != '0) begin
              acc   <= '0;
              q     <= dividend;
              d     <= divisor;
              count <= '0;
              ready <= 1'b0;
              state <= BUSY;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              ready       <= 1'b1;
              state       <= DONE;
            end
          end else begin
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        BUSY: begin
          acc   <= acc_next;
          q     <= q_next;
          count <= count + 1'b1;
          if (last) begin
            quotient    <= q_next;
            remainder   <= acc_next;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            ready       <= 1'b1;
            state       <= DONE;
          end
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
// ============================================================================
// tb_seq_restoring_divider : randomized and directed checks against a / and %
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       ready;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int tests = 0;
  int fails = 0;

  seq_restoring_divider #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .ready(ready), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge where done is seen (or after timeout, lat=0).
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int inject_at,
                        output int lat, output logic [3:0] qo, output logic [3:0] ro,
                        output logic zo, output logic rdy_bad);
    start = 1'b1; dividend = a; divisor = b;
    rdy_bad = 1'b0; lat = 0;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == inject_at) begin
        start = 1'b1; dividend = 4'd15; divisor = 4'd1;
      end else if (n == inject_at + 1) begin
        start = 1'b0;
      end
      if (done) begin
        lat = n;
        break;
      end
      if (ready) rdy_bad = 1'b1;
    end
    start = 1'b0;
    qo = quotient; ro = remainder; zo = div_by_zero;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ready); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if ({quotient, remainder, div_by_zero} !== 9'd0)
      begin fails++; $display("FAIL reset_outputs got q=%0d r=%0d z=%b want 0 0 0", quotient, remainder, div_by_zero); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [3:0] a [4] = '{4'd11, 4'd2, 4'd15, 4'd9};
    logic [3:0] b [4] = '{4'd3, 4'd3, 4'd1, 4'd9};
    int lat; logic [3:0] qo, ro; logic zo, rb;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      run_op(a[i], b[i], 0, lat, qo, ro, zo, rb);
      tests++; if (lat !== 5) begin fails++; $display("FAIL basic_latency %0d/%0d got %0d want 5", a[i], b[i], lat); end
      tests++; if ({qo, ro, zo} !== {a[i] / b[i], a[i] % b[i], 1'b0})
        begin fails++; $display("FAIL basic_result %0d/%0d got q=%0d r=%0d z=%b want q=%0d r=%0d z=0",
                                 a[i], b[i], qo, ro, zo, a[i] / b[i], a[i] % b[i]); end
      tests++; if (rb !== 1'b0) begin fails++; $display("FAIL basic_ready_busy got ready high want low"); end
      @(negedge clk);
      tests++; if ({done, ready} !== 2'b01) begin fails++; $display("FAIL basic_done_pulse got done=%b ready=%b want 0 1", done, ready); end
      tests++; if (quotient !== a[i] / b[i]) begin fails++; $display("FAIL basic_hold got q=%0d want %0d", quotient, a[i] / b[i]); end
    end
  endtask

  task automatic test_div_zero;
    int lat; logic [3:0] qo, ro; logic zo, rb;
    @(negedge clk);
    run_op(4'd7, 4'd0, 0, lat, qo, ro, zo, rb);
    tests++; if (lat !== 1) begin fails++; $display("FAIL dbz_latency got %0d want 1", lat); end
    tests++; if ({qo, ro, zo} !== {4'hF, 4'd7, 1'b1})
      begin fails++; $display("FAIL dbz_result got q=%0d r=%0d z=%b want q=15 r=7 z=1", qo, ro, zo); end
    run_op(4'd6, 4'd2, 0, lat, qo, ro, zo, rb);
    tests++; if ({lat, qo, zo} !== {32'd5, 4'd3, 1'b0})
      begin fails++; $display("FAIL dbz_followup got lat=%0d q=%0d z=%b want lat=5 q=3 z=0", lat, qo, zo); end
  endtask

  task automatic test_ignore_start;
    int lat; logic [3:0] qo, ro; logic zo, rb;
    @(negedge clk);
    run_op(4'd12, 4'd5, 2, lat, qo, ro, zo, rb);
    tests++; if ({lat, qo, ro} !== {32'd5, 4'd2, 4'd2})
      begin fails++; $display("FAIL ignore_result got lat=%0d q=%0d r=%0d want lat=5 q=2 r=2", lat, qo, ro); end
    tests++; if (rb !== 1'b0) begin fails++; $display("FAIL ignore_ready got ready high during busy want low"); end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL ignore_no_second_done got done=%b want 0", done); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [3:0] qo, ro; logic zo, rb; logic saw_done;
    @(negedge clk);
    start = 1'b1; dividend = 4'd14; divisor = 4'd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if ({ready, done, quotient, remainder, div_by_zero} !== 11'b10_0000_0000_0)
      begin fails++; $display("FAIL midreset_outputs got ready=%b done=%b q=%0d r=%0d z=%b want 1 0 0 0 0",
                               ready, done, quotient, remainder, div_by_zero); end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    tests++; if (saw_done !== 1'b0) begin fails++; $display("FAIL midreset_no_done got done pulse want none"); end
    run_op(4'd14, 4'd3, 0, lat, qo, ro, zo, rb);
    tests++; if ({lat, qo, ro} !== {32'd5, 4'd4, 4'd2})
      begin fails++; $display("FAIL midreset_redo got lat=%0d q=%0d r=%0d want lat=5 q=4 r=2", lat, qo, ro); end
  endtask

  task automatic test_exhaustive;
    int lat; logic [3:0] qo, ro; logic zo, rb;
    int exp_lat; logic [3:0] exp_q, exp_r; logic exp_z;
    @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(4'(a), 4'(b), 0, lat, qo, ro, zo, rb);
        exp_z = (b == 0);
        exp_lat = exp_z ? 1 : 5;
        exp_q = exp_z ? 4'hF : 4'(a / b);
        exp_r = exp_z ? 4'(a) : 4'(a % b);
        tests++; if ({lat, qo, ro, zo} !== {exp_lat, exp_q, exp_r, exp_z})
          begin fails++; $display("FAIL exh_model %0d/%0d got lat=%0d q=%0d r=%0d z=%b want lat=%0d q=%0d r=%0d z=%b",
                                   a, b, lat, qo, ro, zo, exp_lat, exp_q, exp_r, exp_z); end
        if (b != 0) begin
          tests++; if (!((int'(qo) * b + int'(ro) == a) && (int'(ro) < b)))
            begin fails++; $display("FAIL exh_invariant %0d/%0d got q=%0d r=%0d", a, b, qo, ro); end
        end
      end
    end
  endtask

  // Operands recovered from 2x2 products: (A*B)/B must give back A exactly.
  task automatic test_product_recovery;
    int lat; logic [3:0] qo, ro; logic zo, rb;
    @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      for (int b = 1; b < 4; b++) begin
        run_op(4'(a * b), 4'(b), 0, lat, qo, ro, zo, rb);
        tests++; if ({qo, ro, zo} !== {4'(a), 4'd0, 1'b0})
          begin fails++; $display("FAIL product_recover (%0d*%0d)/%0d got q=%0d r=%0d z=%b want q=%0d r=0 z=0",
                                   a, b, b, qo, ro, zo, a); end
      end
    end
  endtask

  task automatic test_random;
    int lat; logic [3:0] qo, ro; logic zo, rb;
    logic [3:0] a, b; int inj;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0;
      run_op(a, b, inj, lat, qo, ro, zo, rb);
      if (b == 0) begin
        tests++; if ({lat, qo, ro, zo} !== {32'd1, 4'hF, a, 1'b1})
          begin fails++; $display("FAIL rand_dbz %0d/0 got lat=%0d q=%0d r=%0d z=%b", a, lat, qo, ro, zo); end
      end else begin
        tests++; if ({lat, qo, ro, zo, rb} !== {32'd5, a / b, a % b, 1'b0, 1'b0})
          begin fails++; $display("FAIL rand_div %0d/%0d got lat=%0d q=%0d r=%0d z=%b rdybad=%b want q=%0d r=%0d",
                                   a, b, lat, qo, ro, zo, rb, a / b, a % b); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_exhaustive();
    test_product_recovery();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
